// File: rtl/imm_encoder.sv
// ============================================================================
//  Module      : imm_encoder
//  Description : Scatters a range/alignment-checked immediate into a RISC-V
//                instruction word; expands an out-of-range li into LUI+ADDI.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_encoder #(
    parameter bit          EXPAND_LI = 1'b1,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  immsrc,
    input  logic [31:0] base,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        out_last,
    output logic        err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ONE  = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;

    localparam logic [2:0] c_SRC_I = 3'b000;
    localparam logic [2:0] c_SRC_S = 3'b001;
    localparam logic [2:0] c_SRC_B = 3'b010;
    localparam logic [2:0] c_SRC_J = 3'b011;
    localparam logic [2:0] c_SRC_U = 3'b100;

    // Masks keep the non-immediate fields of base for each format.
    localparam logic [31:0] c_KEEP_I  = 32'h000F_FFFF;
    localparam logic [31:0] c_KEEP_SB = 32'h01FF_F07F;
    localparam logic [31:0] c_KEEP_JU = 32'h0000_0FFF;

    localparam logic [6:0] c_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OP_LUI = 7'b0110111;

    logic [1:0]  r_state;
    logic        r_valid;
    logic [31:0] r_instr;
    logic        r_last;
    logic        r_err;
    logic [31:0] r_addi;

    logic        w_ok;
    logic [31:0] w_word;
    logic        w_is_li;
    logic [19:0] w_hi;
    logic [4:0]  w_rd;
    logic [31:0] w_lui;
    logic [31:0] w_addi;
    logic        w_accept;

    always_comb begin
        w_ok   = 1'b0;
        w_word = base;
        case (immsrc)
            c_SRC_I: begin
                w_ok   = (&imm[31:11]) | (~|imm[31:11]);
                w_word = (base & c_KEEP_I) | {imm[11:0], 20'd0};
            end
            c_SRC_S: begin
                w_ok   = (&imm[31:11]) | (~|imm[31:11]);
                w_word = (base & c_KEEP_SB)
                       | {imm[11:5], 13'd0, imm[4:0], 7'd0};
            end
            c_SRC_B: begin
                w_ok   = ((&imm[31:12]) | (~|imm[31:12])) & ~imm[0];
                w_word = (base & c_KEEP_SB)
                       | {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'd0};
            end
            c_SRC_J: begin
                w_ok   = ((&imm[31:20]) | (~|imm[31:20])) & ~imm[0];
                w_word = (base & c_KEEP_JU)
                       | {imm[20], imm[10:1], imm[11], imm[19:12], 12'd0};
            end
            c_SRC_U: begin
                w_ok   = ~|imm[11:0];
                w_word = (base & c_KEEP_JU) | {imm[31:12], 12'd0};
            end
            default: begin
                w_ok   = 1'b0;
                w_word = base;
            end
        endcase
    end

    // li = ADDI rd, x0, imm; only that exact form may be split.
    assign w_is_li = EXPAND_LI && (immsrc == c_SRC_I) && !w_ok
                   && (base[6:0] == c_OP_IMM) && (base[14:12] == 3'b000)
                   && (base[19:15] == 5'd0);

    // ADDI sign-extends its 12 bits, so round the upper part up when imm[11] is set.
    assign w_rd   = base[11:7];
    assign w_hi   = imm[31:12] + {19'd0, imm[11]};
    assign w_lui  = {w_hi, w_rd, c_OP_LUI};
    assign w_addi = {imm[11:0], w_rd, 3'b000, w_rd, c_OP_IMM};

    assign in_ready = reset & ((r_state == S_IDLE) | ((r_state == S_ONE) & out_ready));
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_instr <= 32'd0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
            r_addi  <= 32'd0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            if (w_is_li) begin
                r_instr <= w_lui;
                r_last  <= 1'b0;
                r_err   <= 1'b0;
                r_addi  <= w_addi;
                r_state <= S_HI;
            end else if (w_ok) begin
                r_instr <= w_word;
                r_last  <= 1'b1;
                r_err   <= 1'b0;
                r_state <= S_ONE;
            end else begin
                r_instr <= NOP_INSTR;
                r_last  <= 1'b1;
                r_err   <= 1'b1;
                r_state <= S_ONE;
            end
        end else if ((r_state == S_HI) && out_ready) begin
            r_instr <= r_addi;
            r_last  <= 1'b1;
            r_err   <= 1'b0;
            r_state <= S_ONE;
        end else if ((r_state == S_ONE) && out_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
        end
    end

    assign out_valid = r_valid;
    assign instr     = r_instr;
    assign out_last  = r_last;
    assign err       = r_err;

endmodule

`default_nettype wire
